// File: rtl/dct_pkg.sv
// dct_pkg: shared definitions for the DCT input path.
//   DATA_W  - SRAM word width (eight 8-bit pixels)
//   BX_W    - log2(words per image row)
//   BY_W    - log2(block rows)
//   ADDR_W  - SRAM address width, {by, r, bx}
//   fetch_state_e - read sequencer FSM states
package dct_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned BX_W   = 6;
   localparam int unsigned BY_W   = 6;
   localparam int unsigned ADDR_W = BY_W + 3 + BX_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/dct_row_fifo.sv
// dct_row_fifo: 2-entry registered FIFO with occupancy output.
// Ports:
//   clk_i, rst_ni   - clock, synchronous active-low reset (contents cleared)
//   flush_i         - empties the FIFO (contents kept, pointers cleared)
//   push_i, data_i  - write side; a push into a full FIFO is accepted only
//                     when a pop frees a slot in the same cycle
//   pop_i           - read side; ignored while empty
//   valid_o, data_o - head entry
//   count_o         - occupancy 0..2
module dct_row_fifo
   import dct_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       cnt_q;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop_i & (cnt_q != 2'd0);
   assign do_push = push_i & ((cnt_q != 2'd2) | do_pop);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign valid_o = (cnt_q != 2'd0);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/dct_blk_fetch_ctrl.sv
// dct_blk_fetch_ctrl: reads the input image SRAM in 8x8-block order and
// hands block rows to the 2D-DCT over valid/ready.
// Ports:
//   clk, reset (sync, active-low), start (pulse, accepted when idle)
//   busy, done (pulse at frame end)
//   mem_cs, mem_addr = {by, r, bx}, mem_rdata (valid 1 cycle after mem_cs)
//   row_valid/row_ready handshake; row_data, row_idx, blk_idx = {by, bx},
//   frame_last (head is row 7 of the final block)
//   stall_cnt - only when FETCH_STALL_CNT_EN is defined: cycles with
//               busy & row_valid & !row_ready, cleared on start and reset
module dct_blk_fetch_ctrl
   import dct_pkg::*;
#(
   parameter int unsigned BX_W   = dct_pkg::BX_W,
   parameter int unsigned BY_W   = dct_pkg::BY_W,
   parameter int unsigned DATA_W = dct_pkg::DATA_W,
   parameter int unsigned ADDR_W = BY_W + 3 + BX_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 mem_cs,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 row_valid,
   input  logic                 row_ready,
   output logic [DATA_W-1:0]    row_data,
   output logic [2:0]           row_idx,
   output logic [BX_W+BY_W-1:0] blk_idx,
   output logic                 frame_last
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0]          stall_cnt
`endif
);

   localparam int unsigned TAG_W = 3 + BY_W + BX_W + 1;
   localparam int unsigned ENT_W = DATA_W + TAG_W;

   fetch_state_e      state_q;
   logic              busy_q;
   logic              done_q;
   logic [2:0]        r_q;
   logic [BX_W-1:0]   bx_q;
   logic [BY_W-1:0]   by_q;
   logic              inflight_q;
   logic [TAG_W-1:0]  tag_q;
   logic [TAG_W-1:0]  tag_d;
   logic [1:0]        fifo_cnt;
   logic [ENT_W-1:0]  head;
   logic              pop;
   logic              issue;
   logic              last_rd;
   logic              flush;

   assign pop     = row_valid & row_ready;
   assign last_rd = (&r_q) & (&bx_q) & (&by_q);
   assign flush   = (state_q == IDLE) & start;
   // Tag layout {r, by, bx, last} so the FIFO head splits straight into
   // row_idx, blk_idx = {by, bx} and frame_last.
   assign tag_d   = {r_q, by_q, bx_q, last_rd};

   // The read on the bus now lands in the FIFO next cycle, so only the
   // in-flight read (landing this cycle) and the FIFO count are charged.
   assign issue = (state_q == RUN) &&
                  (({1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         r_q        <= '0;
         bx_q       <= '0;
         by_q       <= '0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= issue;
         if (issue) begin
            tag_q <= tag_d;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  r_q     <= '0;
                  bx_q    <= '0;
                  by_q    <= '0;
               end
            end
            RUN: begin
               if (issue) begin
                  r_q <= r_q + 3'd1;
                  if (&r_q) begin
                     bx_q <= bx_q + 1'b1;
                     if (&bx_q) begin
                        by_q <= by_q + 1'b1;
                     end
                  end
                  if (last_rd) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Finish once the FIFO is empty after this cycle's pop.
               if (!inflight_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop))) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   dct_row_fifo #(
      .WIDTH(ENT_W)
   ) u_fifo (
      .clk_i  (clk),
      .rst_ni (reset),
      .flush_i(flush),
      .push_i (inflight_q),
      .data_i ({mem_rdata, tag_q}),
      .pop_i  (pop),
      .valid_o(row_valid),
      .data_o (head),
      .count_o(fifo_cnt)
   );

   assign {row_data, row_idx, blk_idx, frame_last} = head;

   assign busy     = busy_q;
   assign done     = done_q;
   assign mem_cs   = issue;
   assign mem_addr = {by_q, r_q, bx_q};

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_q <= '0;
      end else if (flush) begin
         stall_q <= '0;
      end else if (busy_q && row_valid && !row_ready) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dct_blk_fetch_ctrl.sv
// tb_dct_blk_fetch_ctrl: scoreboard bench for dct_blk_fetch_ctrl.
// Expected read addresses and rows are derived from the read index k with
// plain arithmetic and queued at start; a negedge monitor pops and compares.
// Honours FETCH_STALL_CNT_EN for the stall_cnt port.
module tb_dct_blk_fetch_ctrl;

   localparam int NROWS = 32768;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  ridx;
      logic [11:0] blk;
      logic        last;
   } row_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic        mem_cs;
   logic [14:0] mem_addr;
   logic [63:0] mem_rdata = '0;
   logic        row_valid;
   logic        row_ready;
   logic [63:0] row_data;
   logic [2:0]  row_idx;
   logic [11:0] blk_idx;
   logic        frame_last;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   dct_blk_fetch_ctrl #(
      .BX_W  (6),
      .BY_W  (6),
      .DATA_W(64)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .mem_cs    (mem_cs),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_data  (row_data),
      .row_idx   (row_idx),
      .blk_idx   (blk_idx),
      .frame_last(frame_last)
`ifdef FETCH_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // SRAM model: word[i] = i, one cycle latency, garbage when not read.
   always @(posedge clk) begin
      if (mem_cs) mem_rdata <= {49'd0, mem_addr};
      else        mem_rdata <= {$urandom, $urandom};
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_err = 0;
   int   n_checks = 0;
   row_t exp_row_q[$];
   logic [14:0] exp_addr_q[$];
   int   t_start = 0;
   int   exp_done = -1;
   int   cs_frame = 0;
   int   hs_frame = 0;
   int   issued = 0;
   int   consumed = 0;
   int   stall_model = 0;
   bit   frame_done = 1'b0;
   bit   first_pending = 1'b0;
   bit   stalled_prev = 1'b0;
   logic [79:0] held;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference order: 8 rows of a block, then the next block across, then
   // the next block row down. Address = by*512 + r*64 + bx.
   task automatic push_frame();
      int by, bx, r, addr;
      for (int k = 0; k < NROWS; k++) begin
         by   = k / 512;
         bx   = (k % 512) / 8;
         r    = k % 8;
         addr = by * 512 + r * 64 + bx;
         exp_addr_q.push_back(15'(addr));
         exp_row_q.push_back('{data: 64'(addr), ridx: 3'(r),
                               blk: 12'(by * 64 + bx), last: (k == NROWS - 1)});
      end
   endtask

   task automatic clear_model();
      exp_row_q.delete();
      exp_addr_q.delete();
      cs_frame = 0;
      hs_frame = 0;
      issued = 0;
      consumed = 0;
      stall_model = 0;
      frame_done = 1'b0;
      first_pending = 1'b0;
      stalled_prev = 1'b0;
   endtask

   task automatic goto_cycle(input int c);
      do begin
         @(posedge clk);
         #1;
      end while (cyc < c);
   endtask

   // Called at posedge+1 with the design idle.
   task automatic start_frame(input bit timed);
      clear_model();
      push_frame();
      first_pending = 1'b1;
      start = 1'b1;
      t_start = cyc;
      exp_done = timed ? t_start + 32771 : -1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("busy_at_T1", busy, 1);
      chk("cs_at_T1", mem_cs, 1);
   endtask

   task automatic wait_done(input bit rand_ready, output bit ok);
      int guard = 0;
      while (!frame_done && guard < 50000) begin
         if (rand_ready) row_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
         guard++;
      end
      row_ready = 1'b1;
      ok = frame_done;
      if (!frame_done) chk("frame_timeout", 0, 1);
   endtask

   always @(negedge clk) begin
      row_t er;
      if (reset) begin
         if (mem_cs) begin
            issued++;
            cs_frame++;
            if (exp_addr_q.size() == 0) chk("mem_addr_extra", 1, 0);
            else chk("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
         end
         if (row_valid && first_pending) begin
            first_pending = 1'b0;
            chk("first_valid_cycle", 64'(cyc), 64'(t_start + 3));
         end
         if (row_valid && row_ready) begin
            consumed++;
            hs_frame++;
            if (exp_row_q.size() == 0) chk("row_extra", 1, 0);
            else begin
               er = exp_row_q.pop_front();
               chk("row_data", row_data, er.data);
               chk("row_idx", 64'(row_idx), 64'(er.ridx));
               chk("blk_idx", 64'(blk_idx), 64'(er.blk));
               chk("frame_last", 64'(frame_last), 64'(er.last));
            end
         end
         chk("outstanding_le2", 64'(issued - consumed <= 2), 1);
         if (stalled_prev) begin
            chk("stall_valid_hold", row_valid, 1);
            chk("stall_tags_hold", {row_data, row_idx, blk_idx, frame_last}, held);
         end
         stalled_prev = row_valid && !row_ready;
         if (stalled_prev) begin
            held = {row_data, row_idx, blk_idx, frame_last};
            stall_model++;
         end
         if (done) begin
            frame_done = 1'b1;
            chk("busy_at_done", busy, 0);
            chk("cs_at_done", mem_cs, 0);
            if (exp_done >= 0) chk("done_cycle", 64'(cyc), 64'(exp_done));
            chk("cs_count", 64'(cs_frame), 64'(NROWS));
            chk("hs_count", 64'(hs_frame), 64'(NROWS));
            chk("rows_left", 64'(exp_row_q.size()), 0);
         end
      end
   end

   initial begin
      bit ok;
      reset = 1'b0;
      start = 1'b0;
      row_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_cs", mem_cs, 0);
      chk("rst_mem_addr", 64'(mem_addr), 0);
      chk("rst_row_valid", row_valid, 0);
      chk("rst_row_data", row_data, 0);
      chk("rst_row_idx", 64'(row_idx), 0);
      chk("rst_blk_idx", 64'(blk_idx), 0);
      chk("rst_frame_last", frame_last, 0);
`ifdef FETCH_STALL_CNT_EN
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b1;
      goto_cycle(cyc + 2);

      // Reset in the middle of a frame.
      start_frame(1'b0);
      goto_cycle(t_start + 50);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      clear_model();
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_row_valid", row_valid, 0);
      chk("midrst_mem_cs", mem_cs, 0);
      goto_cycle(cyc + 3);

      // Replay from address 0, ready held high, start re-pulsed while busy.
      start_frame(1'b1);
      goto_cycle(t_start + 100);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1'b0, ok);

      // Random backpressure frame.
      if (ok) begin
         goto_cycle(cyc + 2);
         start_frame(1'b0);
         wait_done(1'b1, ok);
         @(negedge clk);
`ifdef FETCH_STALL_CNT_EN
         chk("stall_cnt", stall_cnt, 64'(stall_model));
         goto_cycle(cyc + 5);
         @(negedge clk);
         chk("stall_cnt_hold", stall_cnt, 64'(stall_model));
`endif
         chk("idle_busy", busy, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
